// File: rtl/pipe_pkg.sv
// Shared helpers for the pipe_fifo slice.
// Contents:
//   DEF_WIDTH, DEF_DEPTH : default payload width and entry count
//   clog2()              : ceiling log2 of a positive integer
//   ptr_width()          : read/write pointer width for a given depth (at least 1)
//   cnt_width()          : occupancy counter width, which must be able to hold DEPTH itself
package pipe_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < value) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : clog2(depth);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pipe_fifo_mem.sv
// Storage array for pipe_fifo: one synchronous write port and one asynchronous read port.
// The storage has no reset. Entries are meaningful only while the control logic
// counts them as occupied.
// Ports:
//   clk       : clock
//   wr_en     : write enable
//   wr_addr   : write address
//   wr_data   : write payload
//   rd_addr   : read address
//   rd_data_c : payload at rd_addr (combinational read)
module pipe_fifo_mem
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data_c
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port
  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/pipe_fifo.sv
// pipe_fifo: valid/ready FIFO with circular storage and registered handshake status.
// Optional feature: when the macro PIPE_FIFO_FLUSH_EN is defined, the module has an
// extra input, flush. A flush empties the FIFO in one cycle and drops any push made
// in that same cycle.
// Ports:
//   clk         : clock; all logic switches on the rising edge
//   rst         : synchronous, active-high reset; it takes priority over flush
//   valid_in    : upstream beat valid
//   data_in     : upstream payload
//   ready_out   : registered; upstream may push
//   valid_out   : the head entry is valid
//   data_out    : head entry payload (0 while the FIFO is empty)
//   ready_in    : downstream ready
//   count       : registered occupancy
//   almost_full : registered; high when count >= AFULL
//   flush       : (only with PIPE_FIFO_FLUSH_EN) synchronous empty request
module pipe_fifo
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AFULL = DEPTH - 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_in,
  input  logic [WIDTH-1:0]              data_in,
  output logic                          ready_out,
  output logic                          valid_out,
  output logic [WIDTH-1:0]              data_out,
  input  logic                          ready_in,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          almost_full
`ifdef PIPE_FIFO_FLUSH_EN
  ,
  input  logic                          flush
`endif
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic [WIDTH-1:0] head_data_c;
  logic             push_c;
  logic             pop_c;
  logic             wr_en_c;
  logic             flush_c;

`ifdef PIPE_FIFO_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  // Transfer qualification and next occupancy.
  // ready_out and valid_out are both registered, so neither handshake depends
  // combinationally on the other side's input.
  always_comb begin
    push_c     = valid_in & ready_out;
    pop_c      = valid_out & ready_in;
    wr_en_c    = push_c & ~rst & ~flush_c;
    count_next = count + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // Pointer, occupancy and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ready_out   <= 1'b0;
      valid_out   <= 1'b0;
      almost_full <= 1'b0;
    end else if (flush_c) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ready_out   <= 1'b1;
      valid_out   <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count       <= count_next;
      ready_out   <= (count_next < CNT_W'(DEPTH));
      valid_out   <= (count_next != '0);
      almost_full <= (count_next >= CNT_W'(AFULL));
    end
  end

  pipe_fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk       (clk),
    .wr_en     (wr_en_c),
    .wr_addr   (wr_ptr),
    .wr_data   (data_in),
    .rd_addr   (rd_ptr),
    .rd_data_c (head_data_c)
  );

  // Force the payload to zero while empty. Unoccupied storage, including storage
  // left over from before a reset, is never visible.
  assign data_out = valid_out ? head_data_c : '0;

endmodule

// File: tb/tb_pipe_fifo.sv
// Directed and random checks for pipe_fifo at WIDTH=8, DEPTH=4, AFULL=3.
module tb_pipe_fifo;

  logic       clk;
  logic       rst;
  logic       valid_in;
  logic [7:0] data_in;
  logic       ready_out;
  logic       valid_out;
  logic [7:0] data_out;
  logic       ready_in;
  logic [2:0] count;
  logic       almost_full;
`ifdef PIPE_FIFO_FLUSH_EN
  logic       flush;
`endif

  int checks;
  int failures;

  pipe_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .ready_out   (ready_out),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .ready_in    (ready_in),
    .count       (count),
    .almost_full (almost_full)
`ifdef PIPE_FIFO_FLUSH_EN
    ,
    .flush       (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    data_in  = 8'h00;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b1;
    data_in  = 8'hFF;
`ifdef PIPE_FIFO_FLUSH_EN
    flush    = 1'b0;
`endif
    step();
    step();
    checks++;
    if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++;
    if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++;
    if (ready_out !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready_out); end
    checks++;
    if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
    checks++;
    if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_out); end
    rst = 1'b0;
    step();
    checks++;
    if (ready_out !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", ready_out); end
    checks++;
    if (count !== 3'd0) begin failures++; $display("FAIL reset_release_count got=%0d exp=0", count); end
  endtask

  task automatic test_single_beat();
    ready_in = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'hA5;
    step();
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", valid_out); end
    checks++;
    if (data_out !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", data_out); end
    checks++;
    if (count !== 3'd1) begin failures++; $display("FAIL single_count1 got=%0d exp=1", count); end
    step();
    checks++;
    if (count !== 3'd0) begin failures++; $display("FAIL single_count0 got=%0d exp=0", count); end
    checks++;
    if (valid_out !== 1'b0) begin failures++; $display("FAIL single_valid_after got=%b exp=0", valid_out); end
  endtask

  // ready_in held low: push 0x10..0x14, and only the first four are stored
  task automatic test_fill_overflow();
    logic [2:0] exp_cnt;
    logic       exp_rdy;
    logic       exp_af;
    ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1;
      data_in  = 8'h10 + 8'(i);
      step();
      exp_cnt = (i < 4) ? 3'(i + 1) : 3'd4;
      exp_rdy = (i < 3);
      exp_af  = (i >= 2);
      checks++;
      if (count !== exp_cnt) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, exp_cnt); end
      checks++;
      if (ready_out !== exp_rdy) begin failures++; $display("FAIL fill_ready[%0d] got=%b exp=%b", i, ready_out, exp_rdy); end
      checks++;
      if (almost_full !== exp_af) begin failures++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, almost_full, exp_af); end
    end
    valid_in = 1'b0;
    checks++;
    if (data_out !== 8'h10) begin failures++; $display("FAIL fill_head got=%h exp=10", data_out); end
  endtask

  // Start full (0x10..0x13). Stream with both sides active, wrap the pointers, then drain.
  task automatic test_drain_wrap();
    logic [7:0] q[$];
    logic [7:0] d;
    logic       acc;
    q = '{8'h10, 8'h11, 8'h12, 8'h13};
    d = 8'h20;
    ready_in = 1'b1;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (ready_out !== (q.size() < 4)) begin failures++; $display("FAIL wrap_ready[%0d] got=%b exp=%b", c, ready_out, (q.size() < 4)); end
      checks++;
      if (data_out !== q[0]) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", c, data_out, q[0]); end
      valid_in = 1'b1;
      data_in  = d;
      acc = (q.size() < 4);
      void'(q.pop_front());
      if (acc) begin
        q.push_back(d);
        d = d + 8'h01;
      end
      step();
      checks++;
      if (count !== 3'(q.size())) begin failures++; $display("FAIL wrap_count[%0d] got=%0d exp=%0d", c, count, q.size()); end
    end
    valid_in = 1'b0;
    for (int c = 0; c < 6 && q.size() != 0; c++) begin
      checks++;
      if (data_out !== q[0]) begin failures++; $display("FAIL wrap_drain_data[%0d] got=%h exp=%h", c, data_out, q[0]); end
      void'(q.pop_front());
      step();
    end
    checks++;
    if (valid_out !== 1'b0) begin failures++; $display("FAIL wrap_empty got=%b exp=0", valid_out); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic       push;
    logic       pop;
    int         rnd_fail;
    rnd_fail = 0;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      checks++;
      if (count !== 3'(q.size()) || valid_out !== (q.size() != 0) ||
          ready_out !== (q.size() < 4) || almost_full !== (q.size() >= 3) ||
          (q.size() != 0 && data_out !== q[0])) begin
        failures++;
        rnd_fail++;
        if (rnd_fail < 20)
          $display("FAIL random[%0d] got cnt=%0d v=%b r=%b af=%b d=%h exp cnt=%0d head=%h",
                   c, count, valid_out, ready_out, almost_full, data_out, q.size(),
                   (q.size() != 0) ? q[0] : 8'h00);
      end
      valid_in = 1'($urandom_range(0, 1));
      ready_in = 1'($urandom_range(0, 1));
      data_in  = 8'($urandom_range(0, 255));
      push = valid_in & (q.size() < 4);
      pop  = ready_in & (q.size() != 0);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(data_in);
      step();
    end
    valid_in = 1'b0;
    ready_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1;
      data_in  = 8'h50 + 8'(i);
      step();
    end
    valid_in = 1'b0;
    checks++;
    if (count !== 3'd3) begin failures++; $display("FAIL rstmid_pre_count got=%0d exp=3", count); end
    rst      = 1'b1;
    ready_in = 1'b1;
    step();
    checks++;
    if (valid_out !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", valid_out); end
    checks++;
    if (count !== 3'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", count); end
    checks++;
    if (ready_out !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%b exp=0", ready_out); end
    rst = 1'b0;
    step();
    checks++;
    if (ready_out !== 1'b1) begin failures++; $display("FAIL rstmid_ready_after got=%b exp=1", ready_out); end
    step();
    checks++;
    if (valid_out !== 1'b0) begin failures++; $display("FAIL rstmid_no_emit got=%b exp=0", valid_out); end
  endtask

`ifdef PIPE_FIFO_FLUSH_EN
  task automatic test_flush();
    do_reset();
    flush    = 1'b0;
    ready_in = 1'b0;
    valid_in = 1'b1;
    data_in  = 8'h31;
    step();
    data_in  = 8'h32;
    step();
    checks++;
    if (count !== 3'd2) begin failures++; $display("FAIL flush_pre_count got=%0d exp=2", count); end
    flush   = 1'b1;
    data_in = 8'h99;
    step();
    flush    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    checks++;
    if (count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++;
    if (valid_out !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", valid_out); end
    checks++;
    if (ready_out !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", ready_out); end
    step();
    checks++;
    if (valid_out !== 1'b0) begin failures++; $display("FAIL flush_dropped got=%b exp=0", valid_out); end
    valid_in = 1'b1;
    data_in  = 8'h44;
    step();
    valid_in = 1'b0;
    checks++;
    if (data_out !== 8'h44) begin failures++; $display("FAIL flush_next_data got=%h exp=44", data_out); end
    step();
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_beat();
    test_fill_overflow();
    test_drain_wrap();
    test_random();
    test_reset_mid();
`ifdef PIPE_FIFO_FLUSH_EN
    test_flush();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_fifo.md
PIPE_FIFO -- requirements
Module: pipe_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, entry count; power of 2, >=2.
REQ-003 SHALL have parameter AFULL, default DEPTH-1, almost-full occupancy threshold (1..DEPTH).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port valid_in  input  1  upstream beat valid.
REQ-007 SHALL have port data_in  input  WIDTH  upstream payload.
REQ-008 SHALL have port ready_out  output  1  to upstream, registered, accept permitted.
REQ-009 SHALL have port valid_out  output  1  head entry valid to downstream.
REQ-010 SHALL have port data_out  output  WIDTH  head entry payload.
REQ-011 SHALL have port ready_in  input  1  downstream ready.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, registered.
REQ-013 SHALL have port almost_full  output  1  registered, high when count >= AFULL.

Function
REQ-014 SHALL define push = valid_in & ready_out; pop = valid_out & ready_in; a beat transfers only on these.
REQ-015 SHALL keep entries in FIFO order in circular storage with wr/rd pointers wrapping modulo DEPTH.
REQ-016 SHALL update count_next = count + push - pop; simultaneous push and pop leave count unchanged.
REQ-017 SHALL register ready_out <= (count_next < DEPTH); no combinational path from ready_in or valid_in to ready_out.
REQ-018 SHALL drive valid_out = (count != 0) and data_out = entry at rd pointer; both from registered state only.
REQ-019 SHALL give latency of one cycle: beat pushed at edge t on an empty FIFO is on valid_out/data_out after edge t.
REQ-020 SHALL hold data_out and valid_out stable while valid_out & ~ready_in.
REQ-021 SHALL never overflow: when count==DEPTH, ready_out is 0; a pop there raises ready_out after the same edge.
REQ-022 SHALL never underflow: pop impossible when count==0; ready_in ignored while empty.
REQ-023 SHALL ignore data_in and valid_in when ready_out is 0 (no storage write, no pointer move).
REQ-024 SHALL sustain one beat per cycle throughput with ready_in held high.

Reset
REQ-025 SHALL, while rst high at an edge, clear pointers, count=0, valid_out=0, ready_out=0, almost_full=0, storage contents don't-care except data_out=0.
REQ-026 SHALL raise ready_out on the first edge after rst deasserts (count_next=0 < DEPTH).
REQ-027 SHALL discard all in-flight entries on reset mid-operation; no beat is emitted after reset that was pushed before it.

Configuration
REQ-028 SHALL support macro PIPE_FIFO_FLUSH_EN; defined: adds input flush (1 bit) that on a high edge clears pointers and count, leaves ready_out=1 on the next cycle, and drops any push in that cycle.
REQ-029 SHALL, without PIPE_FIFO_FLUSH_EN, have no flush port and behave per REQ-014..027 only.
REQ-030 SHALL give rst priority over flush when both asserted.

Structure
REQ-031 SHALL place pointer-width/count-width helper constants and ceil-log2 function in shared package pipe_pkg.
REQ-032 SHALL isolate storage in sub-module pipe_fifo_mem (write port: addr, data, enable; asynchronous read at rd pointer).
REQ-033 SHALL keep handshake, pointer and count control in pipe_fifo itself.

Verification
REQ-034 SHALL test: reset, then 1 beat 0xA5 with ready_in=1 -> valid_out high next cycle with data_out=0xA5, count 1 then 0.
REQ-035 SHALL test: DEPTH=4, ready_in=0, push 5 beats -> count 4, ready_out low after 4th push, 5th beat not stored.
REQ-036 SHALL test: full FIFO, ready_in=1, valid_in=1 continuous -> ready_out returns 1 one cycle after first pop, order preserved across pointer wrap.
REQ-037 SHALL test: random valid_in/ready_in for 10k cycles vs reference queue -> no loss, duplication or reorder; count always matches.
REQ-038 SHALL test: rst asserted with count=3 -> next cycle valid_out=0, count=0, ready_out=0; then ready_out=1.
REQ-039 SHALL test, with PIPE_FIFO_FLUSH_EN: flush with count=2 and simultaneous push -> count=0, valid_out=0, pushed beat never appears.
